// File: rtl/uart_pkg.sv
// Shared register map, bit positions and defaults for the APB-attached UART control block.
package uart_pkg;

  localparam logic [31:0] ADDR_RBR_THR = 32'h1000_4000;
  localparam logic [31:0] ADDR_DLH     = 32'h1000_4004;
  localparam logic [31:0] ADDR_LCR     = 32'h1000_400C;
  localparam logic [31:0] ADDR_LSR     = 32'h1000_4014;

  localparam int unsigned OSR     = 16;
  localparam int unsigned DATALEN = 8;

  localparam logic [15:0] DIV_RST_DEFAULT = 16'd27;
  localparam logic [7:0]  LCR_RST         = 8'h03;

  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_OE   = 1;
  localparam int unsigned LSR_THRE = 5;
  localparam int unsigned LSR_TEMT = 6;
  localparam int unsigned LCR_DLAB = 7;

  typedef enum logic [2:0] {
    RegNone,
    RegRbrThr,
    RegDll,
    RegDlh,
    RegLcr,
    RegLsr
  } reg_sel_e;

endpackage

// File: rtl/uart_apb_ctrl_if.sv
// APB3 slave bus bundle for the UART control block.
interface uart_apb_ctrl_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Oversampling baud tick generator: counts 0..divisor-1 and pulses on the last count.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        restart,
  output logic        baud_tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        at_end;

  // A zero divisor never matches, so the counter parks at 0.
  assign at_end    = (divisor != 16'd0) && (cnt_q == divisor - 16'd1);
  assign baud_tick = at_end && !rst;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || (divisor == 16'd0) || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// UART register front end: zero-wait APB3 slave with THR/RBR, divisor latch, LCR and LSR.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] DIV_RST = DIV_RST_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  uart_apb_ctrl_if.slave      apb,
  output logic [DATALEN-1:0]  tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic                tx_busy,
  input  logic [DATALEN-1:0]  rx_data,
  input  logic                rx_valid,
  output logic                baud_tick,
  output logic [7:0]          lcr
);

  logic [7:0]         lcr_q, dll_q, dlh_q;
  logic [DATALEN-1:0] rbr_q, thr_q;
  logic               thr_full_q, dr_q, oe_q;

  reg_sel_e   sel;
  logic       access, dlab, err, ok, wr, rd;
  logic [7:0] rdata, lsr;
  logic       thr_wr, rbr_rd, lsr_rd, div_wr, oe_set;
  logic       unused_wdata;

  assign unused_wdata = ^apb.pwdata[31:DATALEN];

  assign access = apb.psel && apb.penable;
  assign dlab   = lcr_q[LCR_DLAB];

  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = dr_q;
    lsr[LSR_OE]   = oe_q;
    lsr[LSR_THRE] = !thr_full_q;
    lsr[LSR_TEMT] = !thr_full_q && !tx_busy;
  end

  always_comb begin
    sel = RegNone;
    unique case (apb.paddr)
      ADDR_RBR_THR: sel = dlab ? RegDll : RegRbrThr;
      ADDR_DLH:     sel = dlab ? RegDlh : RegNone;
      ADDR_LCR:     sel = RegLcr;
      ADDR_LSR:     sel = RegLsr;
      default:      sel = RegNone;
    endcase
  end

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    unique case (sel)
      RegNone:   err = 1'b1;
      RegRbrThr: begin
        err   = apb.pwrite && thr_full_q;
        rdata = rbr_q;
      end
      RegDll:    rdata = dll_q;
      RegDlh:    rdata = dlh_q;
      RegLcr:    rdata = lcr_q;
      RegLsr: begin
        err   = apb.pwrite;
        rdata = lsr;
      end
      default:   err = 1'b1;
    endcase
  end

  assign ok = access && !err;
  assign wr = ok && apb.pwrite;
  assign rd = ok && !apb.pwrite;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access && err && !rst;
  assign apb.prdata  = (rd && !rst) ? {24'h0, rdata} : 32'h0;

  assign thr_wr = wr && (sel == RegRbrThr);
  assign rbr_rd = rd && (sel == RegRbrThr);
  assign lsr_rd = rd && (sel == RegLsr);
  assign div_wr = wr && ((sel == RegDll) || (sel == RegDlh));
  // A read of RBR in the same cycle frees the holding slot, so no overrun.
  assign oe_set = rx_valid && dr_q && !rbr_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcr_q      <= LCR_RST;
      {dlh_q, dll_q} <= DIV_RST;
      rbr_q      <= '0;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      dr_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      if (wr && (sel == RegLcr)) lcr_q <= apb.pwdata[7:0];
      if (wr && (sel == RegDll)) dll_q <= apb.pwdata[7:0];
      if (wr && (sel == RegDlh)) dlh_q <= apb.pwdata[7:0];

      if (thr_wr) begin
        thr_q      <= apb.pwdata[DATALEN-1:0];
        thr_full_q <= 1'b1;
      end else if (thr_full_q && tx_ready) begin
        thr_full_q <= 1'b0;
      end

      if (rx_valid && (!dr_q || rbr_rd)) begin
        rbr_q <= rx_data;
        dr_q  <= 1'b1;
      end else if (rbr_rd) begin
        dr_q <= 1'b0;
      end

      if (oe_set) begin
        oe_q <= 1'b1;
      end else if (lsr_rd) begin
        oe_q <= 1'b0;
      end
    end
  end

  assign tx_valid = thr_full_q;
  assign tx_data  = thr_q;
  assign lcr      = lcr_q;

  uart_baud_gen u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .divisor   ({dlh_q, dll_q}),
    .restart   (div_wr),
    .baud_tick (baud_tick)
  );

endmodule
